// File: rtl/pixel_stream_generator_pkg.sv
// Shared state encoding, line geometry and elaboration-time helpers for the pixel stream generator.
// Latency: none; types, constants and functions only.
// Backpressure: none.
package pixel_stream_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Number of active (non-dark) pixels in every line.
    localparam int ACTIVE_PIXELS = 1024;

    // Total line length: leading dark pixels followed by the active pixels.
    function automatic int line_length(input int dark_pixels);
        return dark_pixels + ACTIVE_PIXELS;
    endfunction

    // Clock cycles between modulator toggles for a given square-wave frequency.
    // Evaluated in 64 bits so large clock rates cannot overflow before the divide.
    function automatic logic [31:0] half_period(input longint clock_hz, input longint freq_hz);
        return 32'(clock_hz / (2 * freq_hz));
    endfunction

endpackage

// File: rtl/square_wave_modulator.sv
// Square-wave level generator toggling every HALF_PERIOD0 or HALF_PERIOD1 cycles, chosen by i_select.
// Latency: level low the cycle after restart, first toggle HALF cycles after restart releases.
// Backpressure: none; free-running while restart is low.
module square_wave_modulator #(
    parameter logic [31:0] HALF_PERIOD0 = 32'd1,
    parameter logic [31:0] HALF_PERIOD1 = 32'd1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_select,
    input  logic i_restart,
    output logic o_level
);

    logic [31:0] w_half;
    logic [31:0] r_count;
    logic        r_level;

    assign w_half = i_select ? HALF_PERIOD1 : HALF_PERIOD0;

    // Count cycles within the half period and flip the level when it completes.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= 32'd0;
            r_level <= 1'b0;
        end else if (i_restart) begin
            r_count <= 32'd0;
            r_level <= 1'b0;
        end else if (r_count == w_half - 32'd1) begin
            r_count <= 32'd0;
            r_level <= ~r_level;
        end else begin
            r_count <= r_count + 32'd1;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/pixel_stream_generator.sv
// Session-based synthetic line-scan pixel stream with three square-wave modulated pixels.
// Latency: start one cycle after the enable edge, first strobe (position 0) the cycle after start.
// Backpressure: none; the stream is free-running and the consumer must accept every strobe.
module pixel_stream_generator
    import pixel_stream_generator_pkg::*;
#(
    parameter int CLOCK_FREQUENCY     = 100000000,
    parameter int PIXEL_CLOCK_DIVIDER = 4,
    parameter int DARK_PIXELS_COUNT   = 16,
    parameter int PIXEL0_INDEX        = 63,
    parameter int PIXEL1_INDEX        = 511,
    parameter int PIXEL2_INDEX        = 1023,
    parameter int PIXEL0_FREQUENCY0   = 7500,
    parameter int PIXEL0_FREQUENCY1   = 10000,
    parameter int PIXEL1_FREQUENCY0   = 15000,
    parameter int PIXEL1_FREQUENCY1   = 20000,
    parameter int PIXEL2_FREQUENCY0   = 25000,
    parameter int PIXEL2_FREQUENCY1   = 30000,
    parameter int BRIGHT_VALUE        = 200,
    parameter int DARK_VALUE          = 20,
    parameter int BACKGROUND_VALUE    = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [2:0]  frequency_select,
    input  logic [31:0] session_length,
    output logic [7:0]  data,
    output logic        pixel_strobe,
    output logic        line_sync,
    output logic        start,
    output logic        stop,
    output logic        busy
);

    localparam int          LINE_LEN = line_length(DARK_PIXELS_COUNT);
    localparam logic [31:0] POS0     = 32'(DARK_PIXELS_COUNT + PIXEL0_INDEX - 1);
    localparam logic [31:0] POS1     = 32'(DARK_PIXELS_COUNT + PIXEL1_INDEX - 1);
    localparam logic [31:0] POS2     = 32'(DARK_PIXELS_COUNT + PIXEL2_INDEX - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_enable_q;
    logic [2:0]  r_freq_sel;
    logic [31:0] r_length;
    logic [31:0] r_run_cnt;
    logic [31:0] r_div_cnt;
    logic [31:0] r_pos;
    logic [2:0]  w_mod;
    logic        w_enable_rise;
    logic        w_in_run;
    logic        w_restart;
    logic [7:0]  w_pixel;

    assign w_enable_rise = enable & ~r_enable_q;
    assign w_in_run      = (r_state == ST_RUN);
    // Modulators sit low outside RUN so every session starts from a known phase.
    assign w_restart     = ~w_in_run;

    // Next-state selection for the session sequencer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_enable_rise) w_next = ST_ARM;
            ST_ARM:  w_next = (r_length == 32'd0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                if (!enable || (r_run_cnt == r_length - 32'd1)) w_next = ST_DONE;
            end
            ST_DONE: if (!enable) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // State register, enable edge history and session parameter capture.
    // The enable history resets high so a level held across reset is not seen as a new request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_enable_q <= 1'b1;
            r_freq_sel <= 3'd0;
            r_length   <= 32'd0;
        end else begin
            r_state    <= w_next;
            r_enable_q <= enable;
            if (r_state == ST_IDLE && w_enable_rise) begin
                r_freq_sel <= frequency_select;
                r_length   <= session_length;
            end
        end
    end

    // Session cycle counter, strobe divider and line position, cleared in ARM so RUN opens on position 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_run_cnt <= 32'd0;
            r_div_cnt <= 32'd0;
            r_pos     <= 32'd0;
        end else if (w_in_run) begin
            r_run_cnt <= r_run_cnt + 32'd1;
            r_div_cnt <= (r_div_cnt == 32'(PIXEL_CLOCK_DIVIDER - 1)) ? 32'd0 : r_div_cnt + 32'd1;
            if (r_div_cnt == 32'd0) begin
                r_pos <= (r_pos == 32'(LINE_LEN - 1)) ? 32'd0 : r_pos + 32'd1;
            end
        end else begin
            r_run_cnt <= 32'd0;
            r_div_cnt <= 32'd0;
            r_pos     <= 32'd0;
        end
    end

    square_wave_modulator #(
        .HALF_PERIOD0(half_period(CLOCK_FREQUENCY, PIXEL0_FREQUENCY0)),
        .HALF_PERIOD1(half_period(CLOCK_FREQUENCY, PIXEL0_FREQUENCY1))
    ) u_mod0 (
        .i_clock(clock), .i_reset(reset), .i_select(r_freq_sel[0]), .i_restart(w_restart), .o_level(w_mod[0])
    );

    square_wave_modulator #(
        .HALF_PERIOD0(half_period(CLOCK_FREQUENCY, PIXEL1_FREQUENCY0)),
        .HALF_PERIOD1(half_period(CLOCK_FREQUENCY, PIXEL1_FREQUENCY1))
    ) u_mod1 (
        .i_clock(clock), .i_reset(reset), .i_select(r_freq_sel[1]), .i_restart(w_restart), .o_level(w_mod[1])
    );

    square_wave_modulator #(
        .HALF_PERIOD0(half_period(CLOCK_FREQUENCY, PIXEL2_FREQUENCY0)),
        .HALF_PERIOD1(half_period(CLOCK_FREQUENCY, PIXEL2_FREQUENCY1))
    ) u_mod2 (
        .i_clock(clock), .i_reset(reset), .i_select(r_freq_sel[2]), .i_restart(w_restart), .o_level(w_mod[2])
    );

    // Pixel level for the current line position: dark lead-in, modulated pixels, background elsewhere.
    always_comb begin
        w_pixel = 8'(BACKGROUND_VALUE);
        if (r_pos < 32'(DARK_PIXELS_COUNT)) begin
            w_pixel = 8'd0;
        end else if (r_pos == POS0) begin
            w_pixel = w_mod[0] ? 8'(BRIGHT_VALUE) : 8'(DARK_VALUE);
        end else if (r_pos == POS1) begin
            w_pixel = w_mod[1] ? 8'(BRIGHT_VALUE) : 8'(DARK_VALUE);
        end else if (r_pos == POS2) begin
            w_pixel = w_mod[2] ? 8'(BRIGHT_VALUE) : 8'(DARK_VALUE);
        end
    end

    assign pixel_strobe = w_in_run && (r_div_cnt == 32'd0);
    assign line_sync    = pixel_strobe && (r_pos == 32'd0);
    assign data         = pixel_strobe ? w_pixel : 8'd0;
    assign start        = (r_state == ST_ARM);
    assign stop         = (r_state == ST_DONE);
    assign busy         = (r_state == ST_ARM) || w_in_run;

endmodule

// File: tb/tb_pixel_stream_generator.sv
module tb_pixel_stream_generator;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [2:0]  frequency_select;
    logic [31:0] session_length;
    logic [7:0]  data;
    logic        pixel_strobe;
    logic        line_sync;
    logic        start;
    logic        stop;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [7:0] obs_data [0:20000];
    int strobe_err, data_err, sync_err, ctl_err;
    int n_strobe, n_sync, second_sync_t;
    logic end_stop, end_busy, end_strobe;

    always #5 clock = ~clock;

    pixel_stream_generator dut (
        .clock(clock), .reset(reset), .enable(enable),
        .frequency_select(frequency_select), .session_length(session_length),
        .data(data), .pixel_strobe(pixel_strobe), .line_sync(line_sync),
        .start(start), .stop(stop), .busy(busy)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Expected pixel for line position pos at RUN cycle t. Half periods are hand-computed:
    // 1e8/(2*7500)=6666, 1e8/(2*10000)=5000, 1e8/(2*15000)=3333, 1e8/(2*20000)=2500,
    // 1e8/(2*25000)=2000, 1e8/(2*30000)=1666. Modulators are low for the first half period of RUN.
    function automatic logic [7:0] exp_data(input int pos, input int t, input logic [2:0] fs);
        int h0, h1, h2;
        h0 = fs[0] ? 5000 : 6666;
        h1 = fs[1] ? 2500 : 3333;
        h2 = fs[2] ? 1666 : 2000;
        if (pos < 16)    return 8'd0;
        if (pos == 78)   return ((t / h0) % 2 == 1) ? 8'd200 : 8'd20;
        if (pos == 526)  return ((t / h1) % 2 == 1) ? 8'd200 : 8'd20;
        if (pos == 1038) return ((t / h2) % 2 == 1) ? 8'd200 : 8'd20;
        return 8'd50;
    endfunction

    // Observes a RUN of len cycles starting at RUN cycle 0, tallying deviations from the model.
    task automatic monitor_run(input int len, input logic [2:0] fs);
        strobe_err = 0; data_err = 0; sync_err = 0; ctl_err = 0;
        n_strobe = 0; n_sync = 0; second_sync_t = -1;
        for (int t = 0; t < len; t++) begin
            logic       es, esync;
            logic [7:0] ed;
            int         pos;
            es    = (t % 4) == 0;
            pos   = (t / 4) % 1040;
            esync = es && (pos == 0);
            ed    = es ? exp_data(pos, t, fs) : 8'd0;
            if (pixel_strobe !== es) strobe_err++;
            if (line_sync !== esync) sync_err++;
            if (data !== ed) data_err++;
            if (busy !== 1'b1 || stop !== 1'b0 || start !== 1'b0) ctl_err++;
            if (pixel_strobe === 1'b1) n_strobe++;
            if (line_sync === 1'b1) begin
                n_sync++;
                if (n_sync == 2) second_sync_t = t;
            end
            if (t <= 20000) obs_data[t] = data;
            cyc();
        end
        end_stop   = stop;
        end_busy   = busy;
        end_strobe = pixel_strobe;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; frequency_select = 3'd0; session_length = 32'd0;
        #2;
        total++; if (data !== 8'd0)       begin bad++; $display("FAIL reset_data: got %0d want 0", data); end
        total++; if (pixel_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", pixel_strobe); end
        total++; if (line_sync !== 1'b0)  begin bad++; $display("FAIL reset_sync: got %b want 0", line_sync); end
        total++; if (start !== 1'b0)      begin bad++; $display("FAIL reset_start: got %b want 0", start); end
        total++; if (stop !== 1'b0)       begin bad++; $display("FAIL reset_stop: got %b want 0", stop); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        cyc(); cyc();
        reset = 1'b0;
        cyc(); cyc();
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_zero_length();
        enable = 1'b0; cyc();
        frequency_select = 3'd0; session_length = 32'd0; enable = 1'b1;
        cyc();
        total++; if (start !== 1'b1) begin bad++; $display("FAIL zl_start: got %b want 1", start); end
        total++; if (busy !== 1'b1)  begin bad++; $display("FAIL zl_arm_busy: got %b want 1", busy); end
        total++; if (stop !== 1'b0)  begin bad++; $display("FAIL zl_arm_stop: got %b want 0", stop); end
        cyc();
        total++; if (stop !== 1'b1)  begin bad++; $display("FAIL zl_stop: got %b want 1", stop); end
        total++; if (start !== 1'b0) begin bad++; $display("FAIL zl_start_end: got %b want 0", start); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL zl_busy: got %b want 0", busy); end
        total++; if (pixel_strobe !== 1'b0) begin bad++; $display("FAIL zl_strobe: got %b want 0", pixel_strobe); end
        cyc();
        total++; if (stop !== 1'b1)  begin bad++; $display("FAIL zl_stop_hold: got %b want 1", stop); end
        enable = 1'b0;
        cyc();
        total++; if (stop !== 1'b0)  begin bad++; $display("FAIL zl_idle: got %b want 0", stop); end
    endtask

    task automatic test_default_run();
        enable = 1'b0; cyc();
        frequency_select = 3'b000; session_length = 32'd20000; enable = 1'b1;
        cyc();
        total++; if (start !== 1'b1) begin bad++; $display("FAIL def_start: got %b want 1", start); end
        cyc();
        monitor_run(20000, 3'b000);
        total++; if (strobe_err !== 0) begin bad++; $display("FAIL def_strobe_err: got %0d want 0", strobe_err); end
        total++; if (sync_err !== 0)   begin bad++; $display("FAIL def_sync_err: got %0d want 0", sync_err); end
        total++; if (data_err !== 0)   begin bad++; $display("FAIL def_data_err: got %0d want 0", data_err); end
        total++; if (ctl_err !== 0)    begin bad++; $display("FAIL def_ctl_err: got %0d want 0", ctl_err); end
        total++; if (n_strobe !== 5000) begin bad++; $display("FAIL def_n_strobe: got %0d want 5000", n_strobe); end
        total++; if (n_sync !== 5)     begin bad++; $display("FAIL def_n_sync: got %0d want 5", n_sync); end
        total++; if (second_sync_t !== 4160) begin bad++; $display("FAIL def_line_period: got %0d want 4160", second_sync_t); end
        total++; if (end_stop !== 1'b1) begin bad++; $display("FAIL def_stop_time: got %b want 1", end_stop); end
        total++; if (end_busy !== 1'b0) begin bad++; $display("FAIL def_end_busy: got %b want 0", end_busy); end
        total++; if (end_strobe !== 1'b0) begin bad++; $display("FAIL def_end_strobe: got %b want 0", end_strobe); end
        total++; if (obs_data[60] !== 8'd0)    begin bad++; $display("FAIL def_pos15: got %0d want 0", obs_data[60]); end
        total++; if (obs_data[64] !== 8'd50)   begin bad++; $display("FAIL def_pos16: got %0d want 50", obs_data[64]); end
        total++; if (obs_data[312] !== 8'd20)  begin bad++; $display("FAIL def_p0_line0: got %0d want 20", obs_data[312]); end
        total++; if (obs_data[8632] !== 8'd200) begin bad++; $display("FAIL def_p0_line2: got %0d want 200", obs_data[8632]); end
        total++; if (obs_data[6264] !== 8'd200) begin bad++; $display("FAIL def_p1_line1: got %0d want 200", obs_data[6264]); end
        total++; if (obs_data[4152] !== 8'd20)  begin bad++; $display("FAIL def_p2_line0: got %0d want 20", obs_data[4152]); end
        enable = 1'b0; cyc(); cyc();
        total++; if (stop !== 1'b0) begin bad++; $display("FAIL def_back_idle: got %b want 0", stop); end
    endtask

    task automatic test_freq_select_101();
        enable = 1'b0; cyc();
        frequency_select = 3'b101; session_length = 32'd13000; enable = 1'b1;
        cyc(); cyc();
        frequency_select = 3'b000;
        monitor_run(13000, 3'b101);
        total++; if (strobe_err !== 0) begin bad++; $display("FAIL fs_strobe_err: got %0d want 0", strobe_err); end
        total++; if (data_err !== 0)   begin bad++; $display("FAIL fs_data_err: got %0d want 0", data_err); end
        total++; if (n_strobe !== 3250) begin bad++; $display("FAIL fs_n_strobe: got %0d want 3250", n_strobe); end
        total++; if (n_sync !== 4)     begin bad++; $display("FAIL fs_n_sync: got %0d want 4", n_sync); end
        total++; if (end_stop !== 1'b1) begin bad++; $display("FAIL fs_stop_time: got %b want 1", end_stop); end
        total++; if (obs_data[4472] !== 8'd20)   begin bad++; $display("FAIL fs_p0_line1: got %0d want 20", obs_data[4472]); end
        total++; if (obs_data[8632] !== 8'd200)  begin bad++; $display("FAIL fs_p0_line2: got %0d want 200", obs_data[8632]); end
        total++; if (obs_data[12472] !== 8'd200) begin bad++; $display("FAIL fs_p2_line2: got %0d want 200", obs_data[12472]); end
        enable = 1'b0; cyc(); cyc();
    endtask

    task automatic test_abort();
        enable = 1'b0; cyc();
        frequency_select = 3'b000; session_length = 32'd10000; enable = 1'b1;
        cyc(); cyc();
        repeat (500) cyc();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ab_running: got %b want 1", busy); end
        enable = 1'b0;
        cyc();
        total++; if (stop !== 1'b1) begin bad++; $display("FAIL ab_done: got %b want 1", stop); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ab_busy: got %b want 0", busy); end
        total++; if (pixel_strobe !== 1'b0) begin bad++; $display("FAIL ab_strobe: got %b want 0", pixel_strobe); end
        cyc();
        total++; if (stop !== 1'b0) begin bad++; $display("FAIL ab_idle: got %b want 0", stop); end
    endtask

    task automatic test_reset_mid_run();
        logic saw_activity;
        enable = 1'b0; cyc();
        frequency_select = 3'b000; session_length = 32'd10000; enable = 1'b1;
        cyc(); cyc();
        repeat (300) cyc();
        total++; if (data !== 8'd50) begin bad++; $display("FAIL rr_pre_data: got %0d want 50", data); end
        reset = 1'b1;
        #1;
        total++; if (data !== 8'd0)         begin bad++; $display("FAIL rr_data: got %0d want 0", data); end
        total++; if (pixel_strobe !== 1'b0) begin bad++; $display("FAIL rr_strobe: got %b want 0", pixel_strobe); end
        total++; if (busy !== 1'b0)         begin bad++; $display("FAIL rr_busy: got %b want 0", busy); end
        total++; if (stop !== 1'b0)         begin bad++; $display("FAIL rr_stop: got %b want 0", stop); end
        cyc(); cyc();
        reset = 1'b0;
        saw_activity = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (busy !== 1'b0 || start !== 1'b0 || stop !== 1'b0) saw_activity = 1'b1;
        end
        total++; if (saw_activity !== 1'b0) begin bad++; $display("FAIL rr_no_session: got %b want 0", saw_activity); end
        enable = 1'b0; cyc();
        enable = 1'b1; cyc();
        total++; if (start !== 1'b1) begin bad++; $display("FAIL rr_fresh_start: got %b want 1", start); end
        enable = 1'b0; cyc(); cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_zero_length();
        test_default_run();
        test_freq_select_101();
        test_abort();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
